taxi_mac_pause_ctrl_tx: RTL

Transmit-side LFC (802.3 annex 31B PAUSE) and PFC (annex 31D) generator. It converts level pause requests from RX buffer watermark logic into MAC control frame (MCF) requests: XOFF on assertion, XON on release, and periodic XOFF refresh while asserted. The block sits beside the MCF TX path; that path inserts the addresses and ethertype and has priority over data.

---
 rtl/taxi_mac_pause_ctrl_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/taxi_mac_pause_ctrl_tx.sv
// Transmit LFC/PFC pause generator: turns level pause requests into
// MAC control frame requests, with periodic XOFF refresh.
module taxi_mac_pause_ctrl_tx #(
  parameter int MCF_PARAMS_SIZE = 18,
  parameter bit PFC_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mcf_valid,
  input  logic                         mcf_ready,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  input  logic                         tx_lfc_req,
  input  logic [7:0]                   tx_pfc_req,
  input  logic [15:0]                  cfg_tx_lfc_opcode,
  input  logic                         cfg_tx_lfc_en,
  input  logic [15:0]                  cfg_tx_lfc_quanta,
  input  logic [15:0]                  cfg_tx_lfc_refresh,
  input  logic [15:0]                  cfg_tx_pfc_opcode,
  input  logic                         cfg_tx_pfc_en,
  input  logic [15:0]                  cfg_tx_pfc_quanta,
  input  logic [15:0]                  cfg_tx_pfc_refresh,
  input  logic [9:0]                   cfg_quanta_step,
  input  logic                         cfg_quanta_clk_en,
  output logic                         stat_tx_lfc_pkt,
  output logic                         stat_tx_lfc_xon,
  output logic                         stat_tx_lfc_xoff,
  output logic                         stat_tx_lfc_paused,
  output logic                         stat_tx_pfc_pkt,
  output logic [7:0]                   stat_tx_pfc_xon,
  output logic [7:0]                   stat_tx_pfc_xoff,
  output logic [7:0]                   stat_tx_pfc_paused
);

  localparam int PW = MCF_PARAMS_SIZE * 8;
  localparam int PB = (PW > 144) ? PW : 144;

  if (MCF_PARAMS_SIZE < (PFC_EN ? 18 : 2)) begin : g_size_chk
    $fatal(1, "MCF_PARAMS_SIZE too small for selected mode");
  end

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t      state;
  logic        lfc_eff;
  logic        lfc_sent;
  logic        lfc_snap;
  logic        lfc_qnz;
  logic [7:0]  pfc_eff;
  logic [7:0]  pfc_sent;
  logic [7:0]  pfc_snap;
  logic [7:0]  pfc_ev_r;
  logic        pfc_qnz;
  logic        sel_pfc;
  logic [7:0]  qfrac;
  logic [1:0]  quanta_inc;
  logic [15:0] lfc_cnt;
  logic [15:0] pfc_cnt;

  logic [9:0]    qsum;
  logic [16:0]   lfc_sum;
  logic [16:0]   pfc_sum;
  logic          lfc_due;
  logic          pfc_due;
  logic          lfc_pend;
  logic          pfc_pend;
  logic [15:0]   lfc_q;
  logic [7:0]    pfc_ev;
  logic [PW-1:0] lfc_params;
  logic [PB-1:0] pfc_wide;

  assign qsum    = {2'b00, qfrac} + cfg_quanta_step;
  assign lfc_sum = {1'b0, lfc_cnt} + {15'd0, quanta_inc};
  assign pfc_sum = {1'b0, pfc_cnt} + {15'd0, quanta_inc};

  assign lfc_due = (cfg_tx_lfc_refresh != 16'd0)
                && (lfc_cnt >= cfg_tx_lfc_refresh);
  assign pfc_due = (cfg_tx_pfc_refresh != 16'd0)
                && (pfc_cnt >= cfg_tx_pfc_refresh);

  assign lfc_pend = (lfc_eff != lfc_sent) || lfc_due;
  assign pfc_pend = PFC_EN && ((pfc_eff != pfc_sent) || pfc_due);

  assign stat_tx_lfc_paused = lfc_sent;
  assign stat_tx_pfc_paused = pfc_sent;

  always_comb begin
    lfc_params = '0;
    lfc_q = lfc_eff ? cfg_tx_lfc_quanta : 16'd0;
    lfc_params[7:0]  = lfc_q[15:8];
    lfc_params[15:8] = lfc_q[7:0];
  end

  // Classes that are XOFF now or are leaving XOFF get their enable bit.
  always_comb begin
    pfc_wide = '0;
    pfc_ev = pfc_eff | (pfc_eff ^ pfc_sent);
    pfc_wide[15:8] = pfc_ev;
    for (int k = 0; k < 8; k++) begin
      if (pfc_eff[k]) begin
        pfc_wide[(2+2*k)*8 +: 8] = cfg_tx_pfc_quanta[15:8];
        pfc_wide[(3+2*k)*8 +: 8] = cfg_tx_pfc_quanta[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      mcf_valid        <= 1'b0;
      mcf_opcode       <= 16'd0;
      mcf_params       <= '0;
      lfc_eff          <= 1'b0;
      lfc_sent         <= 1'b0;
      lfc_snap         <= 1'b0;
      lfc_qnz          <= 1'b0;
      pfc_eff          <= 8'd0;
      pfc_sent         <= 8'd0;
      pfc_snap         <= 8'd0;
      pfc_ev_r         <= 8'd0;
      pfc_qnz          <= 1'b0;
      sel_pfc          <= 1'b0;
      qfrac            <= 8'd0;
      quanta_inc       <= 2'd0;
      lfc_cnt          <= 16'd0;
      pfc_cnt          <= 16'd0;
      stat_tx_lfc_pkt  <= 1'b0;
      stat_tx_lfc_xon  <= 1'b0;
      stat_tx_lfc_xoff <= 1'b0;
      stat_tx_pfc_pkt  <= 1'b0;
      stat_tx_pfc_xon  <= 8'd0;
      stat_tx_pfc_xoff <= 8'd0;
    end else begin
      lfc_eff <= tx_lfc_req && cfg_tx_lfc_en;
      pfc_eff <= PFC_EN ? (tx_pfc_req & {8{cfg_tx_pfc_en}}) : 8'd0;

      if (cfg_quanta_clk_en) begin
        qfrac      <= qsum[7:0];
        quanta_inc <= qsum[9:8];
      end else begin
        quanta_inc <= 2'd0;
      end

      stat_tx_lfc_pkt  <= 1'b0;
      stat_tx_lfc_xon  <= 1'b0;
      stat_tx_lfc_xoff <= 1'b0;
      stat_tx_pfc_pkt  <= 1'b0;
      stat_tx_pfc_xon  <= 8'd0;
      stat_tx_pfc_xoff <= 8'd0;

      if (lfc_sent)
        lfc_cnt <= lfc_sum[16] ? 16'hFFFF : lfc_sum[15:0];
      if (|pfc_sent)
        pfc_cnt <= pfc_sum[16] ? 16'hFFFF : pfc_sum[15:0];

      unique case (state)
        IDLE: begin
          if (lfc_pend) begin
            sel_pfc    <= 1'b0;
            lfc_snap   <= lfc_eff;
            lfc_qnz    <= lfc_eff && (cfg_tx_lfc_quanta != 16'd0);
            mcf_opcode <= cfg_tx_lfc_opcode;
            mcf_params <= lfc_params;
            mcf_valid  <= 1'b1;
            state      <= SEND;
          end else if (pfc_pend) begin
            sel_pfc    <= 1'b1;
            pfc_snap   <= pfc_eff;
            pfc_ev_r   <= pfc_ev;
            pfc_qnz    <= cfg_tx_pfc_quanta != 16'd0;
            mcf_opcode <= cfg_tx_pfc_opcode;
            mcf_params <= pfc_wide[PW-1:0];
            mcf_valid  <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (mcf_ready) begin
            mcf_valid <= 1'b0;
            state     <= IDLE;
            if (sel_pfc) begin
              pfc_sent         <= pfc_snap;
              pfc_cnt          <= 16'd0;
              stat_tx_pfc_pkt  <= 1'b1;
              stat_tx_pfc_xoff <= pfc_ev_r & pfc_snap & {8{pfc_qnz}};
              stat_tx_pfc_xon  <= pfc_ev_r & ~(pfc_snap & {8{pfc_qnz}});
            end else begin
              lfc_sent         <= lfc_snap;
              lfc_cnt          <= 16'd0;
              stat_tx_lfc_pkt  <= 1'b1;
              stat_tx_lfc_xoff <= lfc_qnz;
              stat_tx_lfc_xon  <= ~lfc_qnz;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
